// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI master register slice: register addresses,
// bit positions inside CTRL / CMD / STATUS, and reset defaults.
package spi_master_pkg;

  // Register addresses on the 3-bit bus address
  localparam logic [2:0] ADDR_DIVL = 3'd0;
  localparam logic [2:0] ADDR_DIVH = 3'd1;
  localparam logic [2:0] ADDR_CTRL = 3'd2;
  localparam logic [2:0] ADDR_EXT  = 3'd3;
  localparam logic [2:0] ADDR_DATA = 3'd4;
  localparam logic [2:0] ADDR_CMD  = 3'd5;
  localparam logic [2:0] ADDR_CS   = 3'd6;
  localparam logic [2:0] ADDR_RSVD = 3'd7;

  // CTRL bit positions (bit 0 is reserved and always reads 0)
  localparam int CTRL_SPE      = 7;
  localparam int CTRL_BIDIROEN = 6;
  localparam int CTRL_SPC0     = 5;
  localparam int CTRL_CPOL     = 4;
  localparam int CTRL_CPHA     = 3;
  localparam int CTRL_LSBFE    = 2;
  localparam int CTRL_IE       = 1;

  // CMD bit positions on write
  localparam int CMD_START = 0;
  localparam int CMD_STOP  = 1;
  localparam int CMD_READ  = 2;
  localparam int CMD_WRITE = 3;
  localparam int CMD_IACK  = 7;

  // STATUS bit positions on read of the CMD address
  localparam int STATUS_IF   = 0;
  localparam int STATUS_TIP  = 1;
  localparam int STATUS_WFLG = 2;
  localparam int STATUS_RFLG = 3;

  // Reset defaults for the parameterised registers
  localparam logic [15:0] RESET_DIV_DEFAULT = 16'h0000;
  localparam logic [7:0]  RESET_CS_DEFAULT  = 8'h00;

endpackage

// File: rtl/spi_master_irq_ctrl.sv
// Interrupt flag block: holds the transfer-done flag (IF) and the sticky
// read/write event flags, and combines them with the enable into INTR.
module spi_master_irq_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic trnfer_cmplte,
  input  logic iack,
  input  logic irq_read,
  input  logic irq_write,
  input  logic ie,
  output logic irq_flag,
  output logic rflg,
  output logic wflg,
  output logic intr
);

  // Flag registers: a set event always beats a simultaneous acknowledge
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every flop samples the pre-edge
    // values of its neighbours, whatever order the statements are in.
    if (rst) begin
      irq_flag <= 1'b0;
      rflg     <= 1'b0;
      wflg     <= 1'b0;
    end else begin
      if (trnfer_cmplte)  irq_flag <= 1'b1;
      else if (iack)      irq_flag <= 1'b0;

      if (irq_read)       rflg <= 1'b1;
      else if (iack)      rflg <= 1'b0;

      if (irq_write)      wflg <= 1'b1;
      else if (iack)      wflg <= 1'b0;
    end
  end

  // Interrupt request is a pure function of registered flags and enable
  assign intr = ie & (irq_flag | rflg | wflg);

endmodule

// File: rtl/spi_master_registers.sv
// Bus-side 8-bit register file for the SPI master: divisor, mode bits,
// extra-clock control, TX data, chip-select and the pending command bits.
// Reads are a combinational mux; writes land on the next rising edge.
module spi_master_registers
  import spi_master_pkg::*;
#(
  parameter logic [15:0] RESET_DIV = RESET_DIV_DEFAULT,
  parameter logic [7:0]  RESET_CS  = RESET_CS_DEFAULT
) (
  input  logic        CLK_i,
  input  logic        RST_i,
  input  logic [2:0]  AD_i,
  input  logic        WR_i,
  input  logic [7:0]  Data_i,
  output logic [7:0]  Data_o,
  output logic [15:0] Divisor_o,
  output logic        SPE_o,
  output logic        BIDIROEn_o,
  output logic        SPC0_o,
  output logic        CPOL_o,
  output logic        CPHA_o,
  output logic        LSBFE_o,
  input  logic        trnfer_cmplte_i,
  output logic        start_o,
  output logic        stop_o,
  output logic        read_o,
  output logic        write_o,
  output logic [2:0]  SPI_Bit_Ctrl_o,
  output logic [2:0]  Ext_SPI_Clk_Cnt_o,
  output logic        Ext_SPI_Clk_En_o,
  input  logic [7:0]  SPI_Read_Data_i,
  output logic [7:0]  SPI_Write_Data_o,
  output logic [7:0]  SPI_CS_Reg_o,
  input  logic        IRQ_read_i,
  input  logic        IRQ_write_i,
  output logic        INTR_o,
  output logic        TIP_o
);

  logic [15:0] div_q;
  logic [7:0]  ctrl_q;     // bit 0 held at 0
  logic [6:0]  ext_q;
  logic [7:0]  txr_q;
  logic [7:0]  cs_q;
  logic [3:0]  cmd_q;      // {write, read, stop, start}
  logic        irq_flag, rflg, wflg;
  logic        wr_cmd, iack;
  logic [7:0]  status;

  assign wr_cmd = WR_i && (AD_i == ADDR_CMD);
  assign iack   = wr_cmd && Data_i[CMD_IACK];

  // Configuration registers: plain read/write storage
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      div_q  <= RESET_DIV;
      ctrl_q <= 8'h00;
      ext_q  <= 7'h00;
      txr_q  <= 8'h00;
      cs_q   <= RESET_CS;
    end else if (WR_i) begin
      unique case (AD_i)
        ADDR_DIVL: div_q[7:0]  <= Data_i;
        ADDR_DIVH: div_q[15:8] <= Data_i;
        ADDR_CTRL: ctrl_q      <= {Data_i[7:1], 1'b0};
        ADDR_EXT:  ext_q       <= Data_i[6:0];
        ADDR_DATA: txr_q       <= Data_i;
        ADDR_CS:   cs_q        <= Data_i;
        default:   ;  // CMD handled below, address 7 ignores writes
      endcase
    end
  end

  // Pending command bits: a gated CMD write wins over completion, and
  // clearing SPE later does not abort what is already pending
  always_ff @(posedge CLK_i) begin
    if (RST_i)                        cmd_q <= 4'h0;
    else if (wr_cmd && ctrl_q[CTRL_SPE]) cmd_q <= Data_i[3:0];
    else if (trnfer_cmplte_i)         cmd_q <= 4'h0;
  end

  spi_master_irq_ctrl u_irq_ctrl (
    .clk           (CLK_i),
    .rst           (RST_i),
    .trnfer_cmplte (trnfer_cmplte_i),
    .iack          (iack),
    .irq_read      (IRQ_read_i),
    .irq_write     (IRQ_write_i),
    .ie            (ctrl_q[CTRL_IE]),
    .irq_flag      (irq_flag),
    .rflg          (rflg),
    .wflg          (wflg),
    .intr          (INTR_o)
  );

  assign TIP_o = |cmd_q;

  always_comb begin
    status              = 8'h00;
    status[STATUS_IF]   = irq_flag;
    status[STATUS_TIP]  = TIP_o;
    status[STATUS_WFLG] = wflg;
    status[STATUS_RFLG] = rflg;
  end

  // Zero-latency read mux on the bus address
  always_comb begin
    // NOTE: default first so no path through the case leaves Data_o
    // unassigned, which would otherwise infer a latch.
    Data_o = 8'h00;
    unique case (AD_i)
      ADDR_DIVL: Data_o = div_q[7:0];
      ADDR_DIVH: Data_o = div_q[15:8];
      ADDR_CTRL: Data_o = ctrl_q;
      ADDR_EXT:  Data_o = {1'b0, ext_q};
      ADDR_DATA: Data_o = SPI_Read_Data_i;
      ADDR_CMD:  Data_o = status;
      ADDR_CS:   Data_o = cs_q;
      ADDR_RSVD: Data_o = 8'h00;
      default:   Data_o = 8'h00;
    endcase
  end

  assign Divisor_o         = div_q;
  assign SPE_o             = ctrl_q[CTRL_SPE];
  assign BIDIROEn_o        = ctrl_q[CTRL_BIDIROEN];
  assign SPC0_o            = ctrl_q[CTRL_SPC0];
  assign CPOL_o            = ctrl_q[CTRL_CPOL];
  assign CPHA_o            = ctrl_q[CTRL_CPHA];
  assign LSBFE_o           = ctrl_q[CTRL_LSBFE];
  assign SPI_Bit_Ctrl_o    = ext_q[2:0];
  assign Ext_SPI_Clk_Cnt_o = ext_q[5:3];
  assign Ext_SPI_Clk_En_o  = ext_q[6];
  assign SPI_Write_Data_o  = txr_q;
  assign SPI_CS_Reg_o      = cs_q;
  assign start_o           = cmd_q[CMD_START];
  assign stop_o            = cmd_q[CMD_STOP];
  assign read_o            = cmd_q[CMD_READ];
  assign write_o           = cmd_q[CMD_WRITE];

endmodule

// File: tb/tb_spi_master_registers.sv
// Directed self-checking bench for spi_master_registers. Inputs change on
// the falling edge; outputs are sampled just after the falling edge.
module tb_spi_master_registers;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ad;
  logic        wr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [15:0] divisor;
  logic        spe, bidiroen, spc0, cpol, cpha, lsbfe;
  logic        cmplte;
  logic        start, stop, rd_cmd, wr_cmd;
  logic [2:0]  bit_ctrl, ext_cnt;
  logic        ext_en;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic [7:0]  cs;
  logic        irq_read, irq_write;
  logic        intr, tip;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_master_registers dut (
    .CLK_i             (clk),
    .RST_i             (rst),
    .AD_i              (ad),
    .WR_i              (wr),
    .Data_i            (data_in),
    .Data_o            (data_out),
    .Divisor_o         (divisor),
    .SPE_o             (spe),
    .BIDIROEn_o        (bidiroen),
    .SPC0_o            (spc0),
    .CPOL_o            (cpol),
    .CPHA_o            (cpha),
    .LSBFE_o           (lsbfe),
    .trnfer_cmplte_i   (cmplte),
    .start_o           (start),
    .stop_o            (stop),
    .read_o            (rd_cmd),
    .write_o           (wr_cmd),
    .SPI_Bit_Ctrl_o    (bit_ctrl),
    .Ext_SPI_Clk_Cnt_o (ext_cnt),
    .Ext_SPI_Clk_En_o  (ext_en),
    .SPI_Read_Data_i   (rx_data),
    .SPI_Write_Data_o  (tx_data),
    .SPI_CS_Reg_o      (cs),
    .IRQ_read_i        (irq_read),
    .IRQ_write_i       (irq_write),
    .INTR_o            (intr),
    .TIP_o             (tip)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle bus write; outputs reflect it at the following falling edge
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ad = a; data_in = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [2:0] a, input logic [7:0] exp);
    @(negedge clk);
    ad = a;
    #1 check(tag, {8'h00, data_out}, {8'h00, exp});
  endtask

  // One-cycle pulse on completion / IRQ inputs
  task automatic pulse(input logic c, input logic r, input logic w);
    @(negedge clk);
    cmplte = c; irq_read = r; irq_write = w;
    @(negedge clk);
    cmplte = 1'b0; irq_read = 1'b0; irq_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ad = 3'd0; wr = 1'b0; data_in = 8'h00; cmplte = 1'b0;
    rx_data = 8'h00; irq_read = 1'b0; irq_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state of every address and the two status outputs
    for (int i = 0; i < 8; i++) bus_read($sformatf("reset_rd%0d", i), 3'(i), 8'h00);
    check("reset_intr", {15'd0, intr}, 16'h0000);
    check("reset_tip",  {15'd0, tip},  16'h0000);

    // Configuration registers
    bus_write(3'd0, 8'h34);
    bus_write(3'd1, 8'h12);
    bus_write(3'd2, 8'hBE);
    bus_write(3'd3, 8'h6D);
    bus_write(3'd6, 8'hFE);
    #1;
    check("divisor", divisor, 16'h1234);
    check("mode_bits", {10'd0, spe, bidiroen, spc0, cpol, cpha, lsbfe}, 16'b10_1111);
    check("bit_ctrl", {13'd0, bit_ctrl}, 16'd5);
    check("ext_cnt",  {13'd0, ext_cnt},  16'd5);
    check("ext_en",   {15'd0, ext_en},   16'd1);
    check("cs_out",   {8'd0, cs},        16'h00FE);
    bus_read("rd_divl", 3'd0, 8'h34);
    bus_read("rd_divh", 3'd1, 8'h12);
    bus_read("rd_ctrl", 3'd2, 8'hBE);
    bus_read("rd_ext",  3'd3, 8'h6D);
    bus_read("rd_cs",   3'd6, 8'hFE);
    check("intr_idle_ie1", {15'd0, intr}, 16'h0000);

    // Command issue and completion
    bus_write(3'd5, 8'h09);
    #1;
    check("cmd09_bits", {12'd0, wr_cmd, rd_cmd, stop, start}, 16'b1001);
    check("cmd09_tip", {15'd0, tip}, 16'd1);
    bus_read("cmd09_status", 3'd5, 8'h02);
    pulse(1'b1, 1'b0, 1'b0);
    #1;
    check("cmplte_bits", {12'd0, wr_cmd, rd_cmd, stop, start}, 16'b0000);
    check("cmplte_tip", {15'd0, tip}, 16'd0);
    check("cmplte_intr", {15'd0, intr}, 16'd1);
    bus_read("cmplte_status", 3'd5, 8'h01);
    bus_write(3'd5, 8'h80);
    #1 check("iack_intr", {15'd0, intr}, 16'd0);
    bus_read("iack_status", 3'd5, 8'h00);

    // SPE=0 blocks a command write
    bus_write(3'd2, 8'h02);
    bus_write(3'd5, 8'h01);
    #1 check("spe0_start", {15'd0, start}, 16'd0);

    // Write and completion in the same cycle: the write wins
    bus_write(3'd2, 8'h80);
    @(negedge clk);
    ad = 3'd5; data_in = 8'h04; wr = 1'b1; cmplte = 1'b1;
    @(negedge clk);
    wr = 1'b0; cmplte = 1'b0;
    #1 check("wr_beats_cmplte", {12'd0, wr_cmd, rd_cmd, stop, start}, 16'b0100);
    // Completion set beats a simultaneous IACK clear
    @(negedge clk);
    ad = 3'd5; data_in = 8'h80; wr = 1'b1; cmplte = 1'b1;
    @(negedge clk);
    wr = 1'b0; cmplte = 1'b0;
    bus_read("if_set_beats_iack", 3'd5, 8'h01);
    bus_write(3'd5, 8'h80);
    bus_read("if_cleared", 3'd5, 8'h00);

    // Sticky event flags and interrupt enable
    pulse(1'b0, 1'b1, 1'b0);
    bus_read("rflg_status", 3'd5, 8'h08);
    check("rflg_intr_ie0", {15'd0, intr}, 16'd0);
    bus_write(3'd2, 8'h82);
    #1 check("rflg_intr_ie1", {15'd0, intr}, 16'd1);
    @(negedge clk);
    ad = 3'd5; data_in = 8'h80; wr = 1'b1; irq_write = 1'b1;
    @(negedge clk);
    wr = 1'b0; irq_write = 1'b0;
    bus_read("iack_vs_wflg_status", 3'd5, 8'h04);
    check("iack_vs_wflg_intr", {15'd0, intr}, 16'd1);

    // Data path and reserved address
    rx_data = 8'hA5;
    bus_read("rx_data", 3'd4, 8'hA5);
    bus_write(3'd4, 8'h3C);
    #1 check("tx_data", {8'd0, tx_data}, 16'h003C);
    bus_write(3'd7, 8'hFF);
    bus_read("rsvd_rd", 3'd7, 8'h00);

    // Clearing SPE does not abort a pending command
    bus_write(3'd5, 8'h01);
    bus_write(3'd2, 8'h02);
    #1 check("spe_clear_keeps_start", {15'd0, start}, 16'd1);
    check("spe_clear_tip", {15'd0, tip}, 16'd1);

    // Reset mid-command, with a simultaneous CS write that must lose
    @(negedge clk);
    rst = 1'b1; ad = 3'd6; data_in = 8'h55; wr = 1'b1;
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    #1;
    check("rst_cmd_bits", {12'd0, wr_cmd, rd_cmd, stop, start}, 16'b0000);
    check("rst_tip",  {15'd0, tip},  16'd0);
    check("rst_intr", {15'd0, intr}, 16'd0);
    check("rst_div",  divisor, 16'h0000);
    check("rst_cs",   {8'd0, cs}, 16'h0000);
    check("rst_tx",   {8'd0, tx_data}, 16'h0000);
    bus_read("rst_status", 3'd5, 8'h00);
    bus_read("rst_ctrl",   3'd2, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
